// File: rtl/jtag_mem_arbiter_if.sv
// Bundle of every handshake/bus signal around jtag_mem_arbiter: the JTAG
// requester, the system requester, the shared memory port and the debug
// and status signals.
//   slave  : arbiter view (samples requests and memory responses; drives
//            the completions, the memory command and the status signals)
//   master : environment view (requesters plus memory)
interface jtag_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  jtag_req;
  logic                  jtag_write;
  logic [ADDR_WIDTH-1:0] jtag_address;
  logic [DATA_WIDTH-1:0] jtag_write_data;
  logic [DATA_WIDTH-1:0] jtag_read_data;
  logic                  jtag_ready;
  logic                  jtag_error;

  logic                  sys_req;
  logic                  sys_write;
  logic [ADDR_WIDTH-1:0] sys_address;
  logic [DATA_WIDTH-1:0] sys_write_data;
  logic [DATA_WIDTH-1:0] sys_read_data;
  logic                  sys_ready;
  logic                  sys_error;

  logic                  mem_enable;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_ready;
  logic                  mem_error;

  logic                  debug_mode;
  logic [1:0]            owner;
  logic                  timeout_event;

  modport slave (
    input  jtag_req, jtag_write, jtag_address, jtag_write_data,
    output jtag_read_data, jtag_ready, jtag_error,
    input  sys_req, sys_write, sys_address, sys_write_data,
    output sys_read_data, sys_ready, sys_error,
    output mem_enable, mem_write, mem_address, mem_write_data,
    input  mem_read_data, mem_ready, mem_error,
    input  debug_mode,
    output owner, timeout_event
  );

  modport master (
    output jtag_req, jtag_write, jtag_address, jtag_write_data,
    input  jtag_read_data, jtag_ready, jtag_error,
    output sys_req, sys_write, sys_address, sys_write_data,
    input  sys_read_data, sys_ready, sys_error,
    input  mem_enable, mem_write, mem_address, mem_write_data,
    output mem_read_data, mem_ready, mem_error,
    output debug_mode,
    input  owner, timeout_event
  );
endinterface

// File: rtl/jtag_mem_arbiter.sv
// Shares one memory port between the JTAG debug master and the system bus
// master. One access outstanding at a time: IDLE -> GRANT -> DONE -> IDLE.
// Round-robin on ties, JTAG wins every tie while debug_mode is high. An
// access with no memory response for TIMEOUT cycles is aborted as an error.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : jtag_mem_arbiter_if.slave (requesters, memory, debug/status)
// All outputs are registered.
module jtag_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  jtag_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_t;

  localparam logic [1:0]  OWN_NONE = 2'b00;
  localparam logic [1:0]  OWN_JTAG = 2'b01;
  localparam logic [1:0]  OWN_SYS  = 2'b10;
  // Timer holds the number of completed GRANT cycles, so the abort fires
  // at the end of GRANT cycle number TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_timer, w_timer_nxt;
  logic                  r_last_sys, w_last_sys_nxt;
  logic [1:0]            r_owner, w_owner_nxt;
  logic                  r_mem_enable, w_mem_enable_nxt;
  logic                  r_mem_write, w_mem_write_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_address, w_mem_address_nxt;
  logic [DATA_WIDTH-1:0] r_mem_write_data, w_mem_write_data_nxt;
  logic [DATA_WIDTH-1:0] r_jtag_read_data, w_jtag_read_data_nxt;
  logic [DATA_WIDTH-1:0] r_sys_read_data, w_sys_read_data_nxt;
  logic                  r_jtag_ready, w_jtag_ready_nxt;
  logic                  r_jtag_error, w_jtag_error_nxt;
  logic                  r_sys_ready, w_sys_ready_nxt;
  logic                  r_sys_error, w_sys_error_nxt;
  logic                  r_timeout_event, w_timeout_event_nxt;
  logic                  w_grant_sys;
  logic                  w_finish;
  logic                  w_fail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_timer          <= '0;
      r_last_sys       <= 1'b1;
      r_owner          <= OWN_NONE;
      r_mem_enable     <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_jtag_read_data <= '0;
      r_sys_read_data  <= '0;
      r_jtag_ready     <= 1'b0;
      r_jtag_error     <= 1'b0;
      r_sys_ready      <= 1'b0;
      r_sys_error      <= 1'b0;
      r_timeout_event  <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_timer          <= w_timer_nxt;
      r_last_sys       <= w_last_sys_nxt;
      r_owner          <= w_owner_nxt;
      r_mem_enable     <= w_mem_enable_nxt;
      r_mem_write      <= w_mem_write_nxt;
      r_mem_address    <= w_mem_address_nxt;
      r_mem_write_data <= w_mem_write_data_nxt;
      r_jtag_read_data <= w_jtag_read_data_nxt;
      r_sys_read_data  <= w_sys_read_data_nxt;
      r_jtag_ready     <= w_jtag_ready_nxt;
      r_jtag_error     <= w_jtag_error_nxt;
      r_sys_ready      <= w_sys_ready_nxt;
      r_sys_error      <= w_sys_error_nxt;
      r_timeout_event  <= w_timeout_event_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_timer_nxt          = r_timer;
    w_last_sys_nxt       = r_last_sys;
    w_owner_nxt          = r_owner;
    w_mem_enable_nxt     = r_mem_enable;
    w_mem_write_nxt      = r_mem_write;
    w_mem_address_nxt    = r_mem_address;
    w_mem_write_data_nxt = r_mem_write_data;
    w_jtag_read_data_nxt = r_jtag_read_data;
    w_sys_read_data_nxt  = r_sys_read_data;
    w_jtag_ready_nxt     = 1'b0;
    w_jtag_error_nxt     = 1'b0;
    w_sys_ready_nxt      = 1'b0;
    w_sys_error_nxt      = 1'b0;
    w_timeout_event_nxt  = 1'b0;
    w_finish             = 1'b0;
    w_fail               = 1'b0;

    // System wins when alone, or on a tie outside debug mode if JTAG had
    // the previous grant.
    w_grant_sys = bus.sys_req && (!bus.jtag_req || (!bus.debug_mode && !r_last_sys));

    case (r_state)
      S_IDLE: begin
        if (bus.jtag_req || bus.sys_req) begin
          w_state_nxt      = S_GRANT;
          w_timer_nxt      = '0;
          w_last_sys_nxt   = w_grant_sys;
          w_owner_nxt      = w_grant_sys ? OWN_SYS : OWN_JTAG;
          w_mem_enable_nxt = 1'b1;
          if (w_grant_sys) begin
            w_mem_write_nxt      = bus.sys_write;
            w_mem_address_nxt    = bus.sys_address;
            w_mem_write_data_nxt = bus.sys_write_data;
          end else begin
            w_mem_write_nxt      = bus.jtag_write;
            w_mem_address_nxt    = bus.jtag_address;
            w_mem_write_data_nxt = bus.jtag_write_data;
          end
        end
      end

      S_GRANT: begin
        w_timer_nxt = r_timer + 16'd1;
        if (bus.mem_error) begin
          w_finish = 1'b1;
          w_fail   = 1'b1;
        end else if (bus.mem_ready) begin
          w_finish = 1'b1;
          if (!r_mem_write) begin
            if (r_owner == OWN_SYS) w_sys_read_data_nxt  = bus.mem_read_data;
            else                    w_jtag_read_data_nxt = bus.mem_read_data;
          end
        end else if (r_timer == TMO_LAST) begin
          w_finish            = 1'b1;
          w_fail              = 1'b1;
          w_timeout_event_nxt = 1'b1;
        end

        if (w_finish) begin
          w_state_nxt      = S_DONE;
          w_mem_enable_nxt = 1'b0;
          w_jtag_ready_nxt = (r_owner == OWN_JTAG) && !w_fail;
          w_jtag_error_nxt = (r_owner == OWN_JTAG) &&  w_fail;
          w_sys_ready_nxt  = (r_owner == OWN_SYS)  && !w_fail;
          w_sys_error_nxt  = (r_owner == OWN_SYS)  &&  w_fail;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.jtag_read_data = r_jtag_read_data;
  assign bus.jtag_ready     = r_jtag_ready;
  assign bus.jtag_error     = r_jtag_error;
  assign bus.sys_read_data  = r_sys_read_data;
  assign bus.sys_ready      = r_sys_ready;
  assign bus.sys_error      = r_sys_error;
  assign bus.mem_enable     = r_mem_enable;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_write_data = r_mem_write_data;
  assign bus.owner          = r_owner;
  assign bus.timeout_event  = r_timeout_event;

endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// Self-checking bench for jtag_mem_arbiter: a transaction-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_jtag_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  jtag_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  jtag_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  // mode 0: ready after mem_wait wait states; 1: never respond;
  // 2: ready and error together after mem_wait wait states.
  int unsigned mem_wait  = 0;
  int          mem_mode  = 0;
  logic [31:0] mem_rdata = '0;
  int unsigned en_cnt    = 0;

  always @(negedge clk) begin
    bus.mem_ready     <= bus.mem_enable && mem_mode != 1 && en_cnt == mem_wait;
    bus.mem_error     <= bus.mem_enable && mem_mode == 2 && en_cnt == mem_wait;
    bus.mem_read_data <= mem_rdata;
    en_cnt            <= bus.mem_enable ? en_cnt + 1 : 0;
  end

  // ---------------- transaction-level model ----------------
  bit          m_busy = 0, m_done = 0, m_err = 0, m_to = 0, m_last_sys = 1, m_write = 0;
  int          m_who  = 0;
  int unsigned m_cnt  = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_jrd = '0, m_srd = '0;

  // 1 = JTAG, 2 = system
  function automatic int winner(bit j, bit s, bit dbg, bit last_sys);
    if (!s)  return 1;
    if (!j)  return 2;
    if (dbg) return 1;
    return last_sys ? 1 : 2;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 0; m_done <= 0; m_err <= 0; m_to <= 0; m_last_sys <= 1;
      m_who <= 0; m_cnt <= 0; m_jrd <= '0; m_srd <= '0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_busy) begin
      if (bus.mem_error || bus.mem_ready || m_cnt + 1 == TMO) begin
        m_busy <= 0;
        m_done <= 1;
        m_err  <= bus.mem_error || !bus.mem_ready;
        m_to   <= !bus.mem_error && !bus.mem_ready;
        if (!bus.mem_error && bus.mem_ready && !m_write) begin
          if (m_who == 1) m_jrd <= bus.mem_read_data;
          else            m_srd <= bus.mem_read_data;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (bus.jtag_req || bus.sys_req) begin
      m_busy     <= 1;
      m_cnt      <= 0;
      m_who      <= winner(bus.jtag_req, bus.sys_req, bus.debug_mode, m_last_sys);
      m_last_sys <= winner(bus.jtag_req, bus.sys_req, bus.debug_mode, m_last_sys) == 2;
      if (winner(bus.jtag_req, bus.sys_req, bus.debug_mode, m_last_sys) == 2) begin
        m_write <= bus.sys_write;  m_addr <= bus.sys_address;  m_wdata <= bus.sys_write_data;
      end else begin
        m_write <= bus.jtag_write; m_addr <= bus.jtag_address; m_wdata <= bus.jtag_write_data;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("mem_enable",     bus.mem_enable,     m_busy);
    chk("owner",          bus.owner,          (m_busy || m_done) ? m_who : 0);
    chk("jtag_ready",     bus.jtag_ready,     m_done && m_who == 1 && !m_err);
    chk("jtag_error",     bus.jtag_error,     m_done && m_who == 1 &&  m_err);
    chk("sys_ready",      bus.sys_ready,      m_done && m_who == 2 && !m_err);
    chk("sys_error",      bus.sys_error,      m_done && m_who == 2 &&  m_err);
    chk("timeout_event",  bus.timeout_event,  m_done && m_to);
    chk("jtag_read_data", bus.jtag_read_data, m_jrd);
    chk("sys_read_data",  bus.sys_read_data,  m_srd);
    if (m_busy) begin
      chk("mem_write",      bus.mem_write,      m_write);
      chk("mem_address",    bus.mem_address,    m_addr);
      chk("mem_write_data", bus.mem_write_data, m_wdata);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_txn(input bit sys, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int en_cycles, output bit rdy, output bit err, output bit tmo);
    bit fin = 0;
    en_cycles = 0; rdy = 0; err = 0; tmo = 0;
    @(negedge clk);
    if (sys) begin
      bus.sys_write = wr; bus.sys_address = a; bus.sys_write_data = d; bus.sys_req = 1'b1;
    end else begin
      bus.jtag_write = wr; bus.jtag_address = a; bus.jtag_write_data = d; bus.jtag_req = 1'b1;
    end
    for (int i = 0; i < 40 && !fin; i++) begin
      @(posedge clk); #2;
      if (bus.mem_enable) en_cycles++;
      if (sys ? (bus.sys_ready || bus.sys_error) : (bus.jtag_ready || bus.jtag_error)) begin
        fin = 1;
        rdy = sys ? bus.sys_ready : bus.jtag_ready;
        err = sys ? bus.sys_error : bus.jtag_error;
        tmo = bus.timeout_event;
      end
    end
    chk("txn_completed", fin, 1'b1);
    @(negedge clk);
    bus.sys_req  = 1'b0;
    bus.jtag_req = 1'b0;
  endtask

  logic [1:0] g_seq [4];
  int         g_n;

  task automatic collect4();
    logic [1:0] prev = 2'b00;
    g_n = 0;
    for (int i = 0; i < 60 && g_n < 4; i++) begin
      @(posedge clk); #2;
      if (bus.owner != 2'b00 && prev == 2'b00) begin
        g_seq[g_n] = bus.owner;
        g_n++;
      end
      prev = bus.owner;
    end
    chk("grant_count", g_n, 4);
    @(negedge clk);
    bus.jtag_req = 1'b0;
    bus.sys_req  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  int         en_c;
  bit         rdy, err, tmo;
  logic [1:0] exp_rr [4];

  initial begin
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
    bus.jtag_req = 0; bus.jtag_write = 0; bus.jtag_address = '0; bus.jtag_write_data = '0;
    bus.sys_req  = 0; bus.sys_write  = 0; bus.sys_address  = '0; bus.sys_write_data  = '0;
    bus.debug_mode = 0;

    #1 reset_n = 1'b0;
    #1;
    chk("rst_mem_enable", bus.mem_enable, 1'b0);
    chk("rst_owner",      bus.owner,      2'b00);
    chk("rst_jtag_rd",    bus.jtag_read_data, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round robin, both persistent, debug off: first tie goes to JTAG.
    mem_wait = 0; mem_mode = 0; mem_rdata = 32'hA5A5_0001;
    bus.jtag_address = 32'h100; bus.sys_address = 32'h200;
    bus.jtag_req = 1; bus.sys_req = 1;
    collect4();
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), g_seq[i], exp_rr[i]);

    // Debug mode: JTAG wins every tie.
    @(negedge clk);
    bus.debug_mode = 1; mem_rdata = 32'h0000_1111;
    bus.jtag_req = 1; bus.sys_req = 1;
    collect4();
    for (int i = 0; i < 4; i++) chk($sformatf("dbg_grant%0d", i), g_seq[i], 2'b01);
    bus.debug_mode = 0;

    // JTAG zero-wait read of 0xDEADBEEF at 0x10.
    @(negedge clk);
    mem_rdata = 32'hDEAD_BEEF;
    bus.jtag_write = 0; bus.jtag_address = 32'h10; bus.jtag_req = 1;
    @(posedge clk); #2;
    chk("t1_mem_enable",  bus.mem_enable,  1'b1);
    chk("t1_mem_address", bus.mem_address, 32'h10);
    chk("t1_mem_write",   bus.mem_write,   1'b0);
    @(posedge clk); #2;
    chk("t1_jtag_ready",  bus.jtag_ready,     1'b1);
    chk("t1_jtag_rd",     bus.jtag_read_data, 32'hDEAD_BEEF);
    chk("t1_sys_ready",   bus.sys_ready,      1'b0);
    chk("t1_sys_error",   bus.sys_error,      1'b0);
    chk("t1_sys_rd",      bus.sys_read_data,  32'hA5A5_0001);
    @(negedge clk); bus.jtag_req = 0;
    @(posedge clk); #2;
    chk("t1_ready_once",  bus.jtag_ready, 1'b0);

    // System write with 3 wait states.
    mem_wait = 3; mem_rdata = 32'hFFFF_0000;
    do_txn(1, 1, 32'h40, 32'h1234_5678, en_c, rdy, err, tmo);
    chk("t3_en_cycles", en_c, 4);
    chk("t3_ready",     rdy,  1'b1);
    chk("t3_error",     err,  1'b0);
    chk("t3_sys_rd",    bus.sys_read_data, 32'hA5A5_0001);

    // Timeout: memory never answers.
    mem_wait = 0; mem_mode = 1;
    do_txn(0, 0, 32'h20, 32'h0, en_c, rdy, err, tmo);
    chk("t4_en_cycles", en_c, TMO);
    chk("t4_error",     err,  1'b1);
    chk("t4_ready",     rdy,  1'b0);
    chk("t4_timeout",   tmo,  1'b1);
    @(posedge clk); #2;
    chk("t4_idle_owner", bus.owner,         2'b00);
    chk("t4_idle_to",    bus.timeout_event, 1'b0);

    // mem_ready and mem_error together: error wins, read data kept.
    mem_mode = 2; mem_rdata = 32'hBAD0_BAD0;
    do_txn(0, 0, 32'h30, 32'h0, en_c, rdy, err, tmo);
    chk("t5_error",   err, 1'b1);
    chk("t5_ready",   rdy, 1'b0);
    chk("t5_timeout", tmo, 1'b0);
    chk("t5_jtag_rd", bus.jtag_read_data, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of a GRANT.
    mem_mode = 1;
    @(negedge clk);
    bus.jtag_write = 0; bus.jtag_address = 32'h80; bus.jtag_req = 1;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_mem_enable", bus.mem_enable,     1'b0);
    chk("t6_mem_addr",   bus.mem_address,    32'h0);
    chk("t6_mem_write",  bus.mem_write,      1'b0);
    chk("t6_mem_wdata",  bus.mem_write_data, 32'h0);
    chk("t6_owner",      bus.owner,          2'b00);
    chk("t6_jtag_rd",    bus.jtag_read_data, 32'h0);
    chk("t6_sys_rd",     bus.sys_read_data,  32'h0);
    chk("t6_jtag_err",   bus.jtag_error,     1'b0);
    chk("t6_timeout",    bus.timeout_event,  1'b0);
    bus.jtag_req = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mem_mode = 0; mem_wait = 0;
    repeat (3) @(negedge clk);
    bus.jtag_req = 1; bus.sys_req = 1;
    @(posedge clk); #2;
    chk("t6_first_tie", bus.owner, 2'b01);
    @(negedge clk);
    bus.jtag_req = 0; bus.sys_req = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jtag_mem_arbiter.md
# jtag_mem_arbiter

Two-port arbiter that shares one memory port between the JTAG debug master (the `jtag_memory_interface` side) and a system bus master. It sits between both requesters and the memory's enable/ready/error port. It registers the winning command, sequences a single outstanding access, and enforces a bus timeout. Arbitration is round-robin, with a JTAG-priority override in debug mode.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 255, cycles in GRANT without mem_ready/mem_error before abort (1..65535)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  reset, asynchronous, active-low
- jtag_req  in  1  JTAG request; held with stable command until jtag_ready/jtag_error
- jtag_write  in  1  1=write, 0=read
- jtag_address  in  ADDR_WIDTH  JTAG address
- jtag_write_data  in  DATA_WIDTH  JTAG write data
- jtag_read_data  out  DATA_WIDTH  JTAG read result, held until next JTAG read completion
- jtag_ready  out  1  one-cycle completion pulse
- jtag_error  out  1  one-cycle error pulse
- sys_req, sys_write, sys_address, sys_write_data, sys_read_data, sys_ready, sys_error  same as jtag_* for the system master
- mem_enable  out  1  memory access strobe, held high for the whole GRANT
- mem_write  out  1  registered command
- mem_address  out  ADDR_WIDTH  registered address
- mem_write_data  out  DATA_WIDTH  registered write data
- mem_read_data  in  DATA_WIDTH  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion
- mem_error  in  1  memory error
- debug_mode  in  1  1=JTAG wins every tie
- owner  out  2  00 none, 01 JTAG, 10 system
- timeout_event  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, GRANT, DONE.
- IDLE:
  - If no request, stay.
  - If one request, grant it.
  - If both request: debug_mode=1 grants JTAG. Otherwise the master not granted last wins.
- Grant edge:
  - Latch write/address/write_data from the winner.
  - Set owner and last_grant.
  - Go to GRANT.
  - Requester changes to command inputs after this edge are ignored.
- last_grant reset value is system, so JTAG wins the first tie.
- GRANT:
  - mem_enable=1, timer counts.
  - On mem_error go to DONE with error. mem_error wins over a simultaneous mem_ready.
  - On mem_ready go to DONE with success. For a read, capture mem_read_data into the owner's read_data register.
  - If the timer reaches TIMEOUT without either response, go to DONE with error and pulse timeout_event with the DONE cycle.
- DONE:
  - Exactly one cycle; mem_enable=0.
  - The owner sees ready or error high for that one cycle.
  - owner clears to 00 on exit; next state is IDLE.
  - No request is sampled in DONE. The requester must drop req on the edge ending DONE.
- A requester that drops req during GRANT does not cancel the access. It completes and pulses normally.
- The non-owner's read_data, ready and error never change during another master's access.
- Write completions never modify read_data.
- The timer is 16 bits and clears on every entry to GRANT.

## Timing
- Reset (asynchronous, any state):
  - FSM goes to IDLE and the timer clears.
  - The in-flight access is abandoned with no ready/error pulse.
  - All outputs go to 0: mem_*, *_ready, *_error, *_read_data, owner, timeout_event.
  - last_grant resets to system.
- Latency, with req high before edge E0 in IDLE:
  - mem_enable is high after E0.
  - If mem_ready is high in that first GRANT cycle, DONE and the ready pulse follow after E1.
  - Minimum latency is 2 edges from request sample to ready visible.
- Back-to-back: the earliest next grant edge is the edge ending the IDLE cycle after DONE. The minimum period is 3 cycles per access with zero-wait memory.
- Timeout: with no response, mem_enable stays high for exactly TIMEOUT cycles. DONE follows in the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- JTAG-only read, memory zero-wait returning 0xDEADBEEF at 0x10:
  - mem_enable is high 1 cycle after the request sample, with mem_address=0x10 and mem_write=0.
  - jtag_ready pulses 1 cycle later, and jtag_read_data=0xDEADBEEF.
  - sys_* outputs stay unchanged.
- Simultaneous requests, debug_mode=0, requesters re-request immediately after each completion, 4 transactions:
  - Grant order is JTAG, SYS, JTAG, SYS.
  - owner sequence is 01,10,01,10.
  - With debug_mode=1, all 4 grants go to JTAG while jtag_req is persistent.
- System write of 0x12345678 to 0x40 with 3 wait states:
  - mem_enable stays high 4 cycles with stable address/data.
  - sys_ready is a single pulse; sys_read_data is unchanged.
- TIMEOUT=8, memory never responds:
  - mem_enable stays high exactly 8 cycles.
  - The owner's error and timeout_event pulse together for one cycle.
  - The FSM then returns to IDLE.
- mem_ready and mem_error asserted in the same cycle:
  - The error pulse fires; the ready pulse does not.
  - read_data keeps its previous value.
- reset_n pulsed low mid-GRANT:
  - All outputs are 0 immediately, asynchronously.
  - No ready/error pulse is issued.
  - The first tie after reset is granted to JTAG.
